spi_mem_controller: RTL and testbench

//  Main-clock-side sequencer for spi_memory_slave. Decodes the SPI command byte, then drives

---
 rtl/spi_mem_controller_pkg.sv | 18 +
 rtl/spi_mem_controller_rise_detect.sv | 19 +
 rtl/spi_mem_controller.sv | 186 ++++++++++++++++++
 tb/tb_spi_mem_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_controller_pkg.sv
// Shared opcodes and FSM state encoding for the SPI memory controller and its benches.
package spi_mem_controller_pkg;

    localparam logic [7:0] OP_WRITE     = 8'h02;
    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_FETCH,
        ST_RD_STREAM,
        ST_WR_STREAM,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_mem_controller_rise_detect.sv
// 1-bit rising-edge detector. The history bit resets high so that a level already
// high when reset releases is not mistaken for a fresh edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/spi_mem_controller.sv
// Main-clock sequencer behind spi_memory_slave: decodes the command byte, steers the slave
// phase flags and streams bytes to/from a register bank with address auto-increment.
module spi_mem_controller
    import spi_mem_controller_pkg::*;
#(
    parameter int         ADDR_WIDTH    = 8,
    parameter int         DATA_WIDTH    = 8,
    parameter logic [7:0] CMD_WRITE     = OP_WRITE,
    parameter logic [7:0] CMD_READ      = OP_READ,
    parameter logic [7:0] CMD_FAST_READ = OP_FAST_READ
) (
    input  logic                  main_clock,
    input  logic                  rst,
    input  logic                  cs,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  addr_valid,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_data_valid,
    input  logic                  read_data_request,
    input  logic                  read_data_captured,
    output logic                  expect_addr,
    output logic                  expect_read,
    output logic                  expect_write,
    output logic                  insert_dummy_cycles,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy
);

    state_t                  state, state_next;
    logic                    cs_prev;
    logic                    addr_rise, wd_rise, req_rise, cap_rise;
    logic                    rd_mode, rd_mode_next;
    logic                    dummy, dummy_next;
    logic                    underrun, underrun_next;
    logic [ADDR_WIDTH-1:0]   counter, counter_next;
    logic                    expect_addr_next, expect_read_next, expect_write_next;
    logic                    insert_dummy_next, reg_we_next, reg_re_next;
    logic [DATA_WIDTH-1:0]   read_data_next, reg_wdata_next;
    logic [ADDR_WIDTH-1:0]   reg_addr_next;
    logic                    cs_fall;

    rise_detect u_addr_rise (.clk(main_clock), .rst(rst), .level(addr_valid),         .rise(addr_rise));
    rise_detect u_wd_rise   (.clk(main_clock), .rst(rst), .level(write_data_valid),   .rise(wd_rise));
    rise_detect u_req_rise  (.clk(main_clock), .rst(rst), .level(read_data_request),  .rise(req_rise));
    rise_detect u_cap_rise  (.clk(main_clock), .rst(rst), .level(read_data_captured), .rise(cap_rise));

    // cs history resets low, so a cs held low through reset never opens a transaction.
    assign cs_fall = cs_prev & ~cs;
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge main_clock) begin
        if (rst) begin
            state               <= ST_IDLE;
            cs_prev             <= 1'b0;
            rd_mode             <= 1'b0;
            dummy               <= 1'b0;
            underrun            <= 1'b0;
            counter             <= '0;
            expect_addr         <= 1'b0;
            expect_read         <= 1'b0;
            expect_write        <= 1'b0;
            insert_dummy_cycles <= 1'b0;
            read_data           <= '0;
            reg_addr            <= '0;
            reg_wdata           <= '0;
            reg_we              <= 1'b0;
            reg_re              <= 1'b0;
        end else begin
            state               <= state_next;
            cs_prev             <= cs;
            rd_mode             <= rd_mode_next;
            dummy               <= dummy_next;
            underrun            <= underrun_next;
            counter             <= counter_next;
            expect_addr         <= expect_addr_next;
            expect_read         <= expect_read_next;
            expect_write        <= expect_write_next;
            insert_dummy_cycles <= insert_dummy_next;
            read_data           <= read_data_next;
            reg_addr            <= reg_addr_next;
            reg_wdata           <= reg_wdata_next;
            reg_we              <= reg_we_next;
            reg_re              <= reg_re_next;
        end
    end

    always_comb begin
        state_next        = state;
        rd_mode_next      = rd_mode;
        dummy_next        = dummy;
        underrun_next     = underrun;
        counter_next      = counter;
        expect_addr_next  = expect_addr;
        expect_read_next  = expect_read;
        expect_write_next = expect_write;
        insert_dummy_next = insert_dummy_cycles;
        read_data_next    = read_data;
        reg_addr_next     = reg_addr;
        reg_wdata_next    = reg_wdata;
        reg_we_next       = 1'b0;
        reg_re_next       = 1'b0;

        // A deasserted cs overrides any edge seen in the same cycle.
        if (cs) begin
            state_next        = ST_IDLE;
            expect_addr_next  = 1'b0;
            expect_read_next  = 1'b0;
            expect_write_next = 1'b0;
            insert_dummy_next = 1'b0;
        end else begin
            if (req_rise && state == ST_RD_FETCH) underrun_next = 1'b1;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_next    = ST_CMD;
                        underrun_next = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (wd_rise) begin
                        if (write_data == DATA_WIDTH'(CMD_READ) ||
                            write_data == DATA_WIDTH'(CMD_FAST_READ)) begin
                            state_next       = ST_ADDR;
                            rd_mode_next     = 1'b1;
                            dummy_next       = (write_data == DATA_WIDTH'(CMD_FAST_READ));
                            expect_addr_next = 1'b1;
                        end else if (write_data == DATA_WIDTH'(CMD_WRITE)) begin
                            state_next       = ST_ADDR;
                            rd_mode_next     = 1'b0;
                            dummy_next       = 1'b0;
                            expect_addr_next = 1'b1;
                        end else begin
                            state_next = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR: begin
                    if (addr_rise) begin
                        counter_next     = addr;
                        expect_addr_next = 1'b0;
                        if (rd_mode) begin
                            reg_re_next       = 1'b1;
                            reg_addr_next     = addr;
                            expect_read_next  = 1'b1;
                            insert_dummy_next = dummy;
                            state_next        = ST_RD_FETCH;
                        end else begin
                            expect_write_next = 1'b1;
                            state_next        = ST_WR_STREAM;
                        end
                    end
                end
                // reg_re is still high on entry; the bank answers one cycle after it drops.
                ST_RD_FETCH: begin
                    if (!reg_re) begin
                        read_data_next = reg_rdata;
                        counter_next   = counter + 1'b1;
                        state_next     = ST_RD_STREAM;
                    end
                end
                ST_RD_STREAM: begin
                    if (cap_rise) begin
                        reg_re_next   = 1'b1;
                        reg_addr_next = counter;
                        state_next    = ST_RD_FETCH;
                    end
                end
                ST_WR_STREAM: begin
                    if (wd_rise) begin
                        reg_addr_next  = counter;
                        reg_wdata_next = write_data;
                        reg_we_next    = 1'b1;
                        counter_next   = counter + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_controller.sv
// Self-checking bench: table of SPI transactions plus hand-written cs/reset abort sequences,
// with a queue scoreboard on the register-bank strobes.
module tb_spi_mem_controller;

    logic       main_clock = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b1;
    logic [7:0] addr = '0;
    logic       addr_valid = 1'b0;
    logic [7:0] write_data = '0;
    logic       write_data_valid = 1'b0;
    logic       read_data_request = 1'b0;
    logic       read_data_captured = 1'b0;
    logic       expect_addr, expect_read, expect_write, insert_dummy_cycles;
    logic [7:0] read_data, reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy;

    spi_mem_controller dut (
        .main_clock(main_clock), .rst(rst), .cs(cs),
        .addr(addr), .addr_valid(addr_valid),
        .write_data(write_data), .write_data_valid(write_data_valid),
        .read_data_request(read_data_request), .read_data_captured(read_data_captured),
        .expect_addr(expect_addr), .expect_read(expect_read), .expect_write(expect_write),
        .insert_dummy_cycles(insert_dummy_cycles), .read_data(read_data),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 main_clock = ~main_clock;

    // Register bank: synchronous read, reset fills it with addr ^ 0x5A.
    logic [7:0] mem [256];
    always @(posedge main_clock) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            reg_rdata <= '0;
        end else begin
            if (reg_we) mem[reg_addr] <= reg_wdata;
            if (reg_re) reg_rdata <= mem[reg_addr];
        end
    end

    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    int         checks = 0;
    int         passes = 0;
    int         strobe_errors = 0;
    logic       prev_we = 1'b0, prev_re = 1'b0;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Strobes are sampled mid-cycle and matched against what the stimulus queued.
    always @(negedge main_clock) begin
        if (!rst) begin
            if (reg_we && reg_re) strobe_errors++;
            if ((reg_we && prev_we) || (reg_re && prev_re)) strobe_errors++;
            if (reg_we) begin
                if (wr_q.size() == 0) strobe_errors++;
                else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    checkOutput("wr_addr", {8'h0, reg_addr}, {8'h0, e.a});
                    checkOutput("wr_data", {8'h0, reg_wdata}, {8'h0, e.d});
                end
            end
            if (reg_re) begin
                if (rd_q.size() == 0) strobe_errors++;
                else checkOutput("rd_addr", {8'h0, reg_addr}, {8'h0, rd_q.pop_front()});
            end
        end
        prev_we = reg_we;
        prev_re = reg_re;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge main_clock);
        #1;
    endtask

    // One SPI byte; snap holds {expect_addr, expect_read, expect_write, dummy} one cycle after the edge.
    task automatic spi_byte(input bit to_addr, input logic [7:0] b, output logic [3:0] snap);
        if (to_addr) addr = b; else write_data = b;
        tick(1);
        if (to_addr) addr_valid = 1'b1; else write_data_valid = 1'b1;
        tick(1);
        snap = {expect_addr, expect_read, expect_write, insert_dummy_cycles};
        tick(2);
        addr_valid = 1'b0;
        write_data_valid = 1'b0;
        tick(3);
    endtask

    task automatic pulse_captured();
        read_data_captured = 1'b1;
        tick(3);
        read_data_captured = 1'b0;
        tick(3);
    endtask

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] start;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [3:0] snap_cmd;
        logic [3:0] snap_addr;
    } vec_t;

    task automatic end_transaction();
        cs = 1'b1;
        tick(2);
        checkOutput("idle_busy", {15'h0, busy}, 16'h0);
        checkOutput("idle_flags", {12'h0, expect_addr, expect_read, expect_write, insert_dummy_cycles}, 16'h0);
        checkOutput("wr_q_empty", 16'(wr_q.size()), 16'h0);
        checkOutput("rd_q_empty", 16'(rd_q.size()), 16'h0);
        checkOutput("strobe_errors", 16'(strobe_errors), 16'h0);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [3:0] snap;
        bit is_wr, is_rd;
        is_wr = (v.opcode == 8'h02);
        is_rd = (v.opcode == 8'h03) || (v.opcode == 8'h0B);
        cs = 1'b0;
        tick(2);
        checkOutput("busy_start", {15'h0, busy}, 16'h1);
        spi_byte(1'b0, v.opcode, snap);
        checkOutput("snap_cmd", {12'h0, snap}, {12'h0, v.snap_cmd});
        if (is_rd) rd_q.push_back(v.start);
        spi_byte(1'b1, v.start, snap);
        checkOutput("snap_addr", {12'h0, snap}, {12'h0, v.snap_addr});
        if (is_wr) begin
            wr_q.push_back({v.start, v.d0});
            spi_byte(1'b0, v.d0, snap);
            wr_q.push_back({v.start + 8'd1, v.d1});
            spi_byte(1'b0, v.d1, snap);
            checkOutput("expect_write_hold", {15'h0, expect_write}, 16'h1);
        end else if (is_rd) begin
            checkOutput("read_first", {8'h0, read_data}, {8'h0, v.d0});
            read_data_request = 1'b1;
            tick(2);
            read_data_request = 1'b0;
            rd_q.push_back(v.start + 8'd1);
            pulse_captured();
            checkOutput("read_second", {8'h0, read_data}, {8'h0, v.d1});
        end else begin
            spi_byte(1'b0, v.d0, snap);
            spi_byte(1'b0, v.d1, snap);
            pulse_captured();
            checkOutput("ignore_flags", {12'h0, expect_addr, expect_read, expect_write, insert_dummy_cycles}, 16'h0);
        end
        end_transaction();
    endtask

    vec_t vecs[8];

    initial begin
        logic [3:0] snap;
        vecs[0] = '{8'h02, 8'h10, 8'hA5, 8'h5A, 4'b1000, 4'b0010};
        vecs[1] = '{8'h02, 8'hFF, 8'h11, 8'h22, 4'b1000, 4'b0010};
        vecs[2] = '{8'h02, 8'hAB, 8'h53, 8'h77, 4'b1000, 4'b0010};
        vecs[3] = '{8'h03, 8'hAB, 8'h53, 8'h77, 4'b1000, 4'b0100};
        vecs[4] = '{8'h0B, 8'h20, 8'h7A, 8'h7B, 4'b1000, 4'b0101};
        vecs[5] = '{8'h03, 8'hFF, 8'h11, 8'h22, 4'b1000, 4'b0100};
        vecs[6] = '{8'h9F, 8'h40, 8'h01, 8'h02, 4'b0000, 4'b0000};
        vecs[7] = '{8'h03, 8'h10, 8'hA5, 8'h5A, 4'b1000, 4'b0100};

        tick(3);
        rst = 1'b0;
        tick(1);
        checkOutput("reset_flags", {9'h0, expect_addr, expect_read, expect_write, insert_dummy_cycles, reg_we, reg_re, busy}, 16'h0);
        checkOutput("reset_read_data", {8'h0, read_data}, 16'h0);
        checkOutput("reset_reg_addr", {reg_wdata, reg_addr}, 16'h0);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // cs rises together with a data edge mid-write: that byte must be dropped.
        cs = 1'b0;
        tick(2);
        spi_byte(1'b0, 8'h02, snap);
        spi_byte(1'b1, 8'h30, snap);
        wr_q.push_back({8'h30, 8'hEE});
        spi_byte(1'b0, 8'hEE, snap);
        write_data = 8'h99;
        tick(1);
        cs = 1'b1;
        write_data_valid = 1'b1;
        tick(3);
        write_data_valid = 1'b0;
        tick(3);
        end_transaction();
        applyStimulus('{8'h03, 8'h30, 8'hEE, 8'h6B, 4'b1000, 4'b0100});

        // Reset mid-write with cs held low and data valid high across release.
        cs = 1'b0;
        tick(2);
        spi_byte(1'b0, 8'h02, snap);
        spi_byte(1'b1, 8'h50, snap);
        write_data = 8'h44;
        write_data_valid = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        write_data_valid = 1'b0;
        tick(1);
        checkOutput("rst_busy", {15'h0, busy}, 16'h0);
        checkOutput("rst_read_data", {8'h0, read_data}, 16'h0);
        spi_byte(1'b0, 8'h02, snap);
        checkOutput("stale_cs_busy", {15'h0, busy}, 16'h0);
        end_transaction();
        applyStimulus('{8'h03, 8'h50, 8'h0A, 8'h0B, 4'b1000, 4'b0100});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
